// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode and datapath-select encodings shared by the
// multi-cycle controller and its datapath.
package mc_ctrl_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JAL    = 4'd10;
  localparam logic [3:0] S_LUI    = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd12;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_OLDPC = 2'b01;
  localparam logic [1:0] SA_RS1   = 2'b10;

  localparam logic [1:0] SB_RS2  = 2'b00;
  localparam logic [1:0] SB_IMM  = 2'b01;
  localparam logic [1:0] SB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_UIMM   = 2'b11;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,
    ALUOP_SUB = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } aluop_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcsrc;
    logic       adrsrc;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] immsrc;
    logic [1:0] resultsrc;
    aluop_t     aluop;
    logic       halted;
  } ctl_t;

  // Dispatch out of DECODE; anything outside the supported subset parks in HALT.
  function automatic logic [3:0] decode_next(input logic [6:0] op);
    return (op == OP_LW || op == OP_SW) ? S_MEMADR :
           (op == OP_R)   ? S_EXECR  :
           (op == OP_I)   ? S_EXECI  :
           (op == OP_BEQ) ? S_BRANCH :
           (op == OP_JAL) ? S_JAL    :
           (op == OP_LUI) ? S_LUI    : S_HALT;
  endfunction

endpackage

// File: rtl/mc_ctrl_aludec.sv
// mc_ctrl_aludec: maps the controller's 2-bit aluop and the instruction
// funct fields onto the 4-bit ALU operation code.
module mc_ctrl_aludec
  import mc_ctrl_pkg::*;
(
  input  aluop_t     aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = (aluop_i == ALUOP_SUB) ? 4'b1000 :
                   (aluop_i == ALUOP_R)   ? {funct7b5_i, funct3_i} :
                   (aluop_i == ALUOP_I)   ? {1'b0, funct3_i} : 4'b0000;
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: Moore FSM sequencing one RV32 instruction at a time through a
// shared-ALU, single-memory-port datapath with a ready handshake on memory.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pcwrite_o,
  output logic       pcsrc_o,
  output logic       adrsrc_o,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       irwrite_o,
  output logic       regwrite_o,
  output logic [1:0] alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [2:0] immsrc_o,
  output logic [1:0] resultsrc_o,
  output logic [3:0] alucontrol_o,
  output logic       halted_o,
  output logic [3:0] state_o
);

  logic [3:0] state_q, state_d;
  ctl_t       ctl;
  logic [5:0] unused_f7;

  assign unused_f7 = {funct7_i[6], funct7_i[4:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: state_d = decode_next(op_i);
      S_MEMADR: state_d = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready_i ? S_FETCH : S_MEMWR;
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_LUI: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.adrsrc    = 1'b0;
        ctl.memread   = 1'b1;
        ctl.alusrca   = SA_PC;
        ctl.alusrcb   = SB_FOUR;
        ctl.aluop     = ALUOP_ADD;
        ctl.resultsrc = RES_ALU;
        ctl.pcsrc     = 1'b0;
        ctl.irwrite   = mem_ready_i;
        ctl.pcwrite   = mem_ready_i;
      end
      S_DECODE: begin
        ctl.alusrca = SA_OLDPC;
        ctl.alusrcb = SB_IMM;
        ctl.aluop   = ALUOP_ADD;
        ctl.immsrc  = (op_i == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        ctl.alusrca = SA_RS1;
        ctl.alusrcb = SB_IMM;
        ctl.aluop   = ALUOP_ADD;
        ctl.immsrc  = (op_i == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEMRD: begin
        ctl.adrsrc  = 1'b1;
        ctl.memread = 1'b1;
      end
      S_MEMWB: begin
        ctl.resultsrc = RES_RDATA;
        ctl.regwrite  = 1'b1;
      end
      S_MEMWR: begin
        ctl.adrsrc   = 1'b1;
        ctl.memwrite = 1'b1;
      end
      S_EXECR: begin
        ctl.alusrca = SA_RS1;
        ctl.alusrcb = SB_RS2;
        ctl.aluop   = ALUOP_R;
      end
      S_EXECI: begin
        ctl.alusrca = SA_RS1;
        ctl.alusrcb = SB_IMM;
        ctl.aluop   = ALUOP_I;
        ctl.immsrc  = IMM_I;
      end
      S_ALUWB: begin
        ctl.resultsrc = RES_ALUOUT;
        ctl.regwrite  = 1'b1;
      end
      S_BRANCH: begin
        ctl.alusrca = SA_RS1;
        ctl.alusrcb = SB_RS2;
        ctl.aluop   = ALUOP_SUB;
        ctl.pcsrc   = 1'b1;
        ctl.pcwrite = zero_i;
      end
      S_JAL: begin
        ctl.alusrca   = SA_OLDPC;
        ctl.alusrcb   = SB_FOUR;
        ctl.aluop     = ALUOP_ADD;
        ctl.resultsrc = RES_ALU;
        ctl.regwrite  = 1'b1;
        ctl.pcsrc     = 1'b1;
        ctl.pcwrite   = 1'b1;
      end
      S_LUI: begin
        ctl.resultsrc = RES_UIMM;
        ctl.immsrc    = IMM_U;
        ctl.regwrite  = 1'b1;
      end
      S_HALT:  ctl.halted = 1'b1;
      default: ;
    endcase
  end

  mc_ctrl_aludec u_aludec (
    .aluop_i      (ctl.aluop),
    .funct3_i     (funct3_i),
    .funct7b5_i   (funct7_i[5]),
    .alucontrol_o (alucontrol_o)
  );

  // Strobes are gated by reset directly so a held-off access drops in the same cycle.
  assign pcwrite_o   = rst_n & ctl.pcwrite;
  assign irwrite_o   = rst_n & ctl.irwrite;
  assign regwrite_o  = rst_n & ctl.regwrite;
  assign memread_o   = rst_n & ctl.memread;
  assign memwrite_o  = rst_n & ctl.memwrite;
  assign pcsrc_o     = ctl.pcsrc;
  assign adrsrc_o    = ctl.adrsrc;
  assign alusrca_o   = ctl.alusrca;
  assign alusrcb_o   = ctl.alusrcb;
  assign immsrc_o    = ctl.immsrc;
  assign resultsrc_o = ctl.resultsrc;
  assign halted_o    = ctl.halted;
  assign state_o     = state_q;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencing controller for the RISC-V core: a Moore FSM that steps one instruction through fetch, decode, execute, memory and writeback over several clocks, driving a shared-ALU, single-memory-port datapath. It supports the core's existing subset: LUI, R-type, I-type ALU, LW, SW, BEQ and JAL. A ready handshake stretches memory states for wait-states. Unknown opcodes park the core in a halt state.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pcwrite  out  1  PC register load
- pcsrc  out  1  PC input: 0 = result bus, 1 = aluout register
- adrsrc  out  1  memory address: 0 = pc, 1 = aluout register
- memread  out  1  read request
- memwrite  out  1  write request
- irwrite  out  1  instruction register and oldpc load
- regwrite  out  1  register-file write
- alusrca  out  2  00 = pc, 01 = oldpc, 10 = rs1
- alusrcb  out  2  00 = rs2, 01 = immext, 10 = constant 4
- immsrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- resultsrc  out  2  00 = aluout register, 01 = readdata, 10 = ALU result, 11 = U-immediate
- alucontrol  out  4  ALU operation
- halted  out  1  FSM is in HALT
- state  out  4  current state, for debug

## Operation
- Outputs are Moore-decoded from state. Exceptions: immsrc is decoded from op; pcwrite in BEQ equals zero; pcwrite and irwrite in FETCH are gated by mem_ready.
- Any select not listed for a state is 0. Write strobes not listed are 0.
- FETCH: adrsrc=0, memread=1, alusrca=00, alusrcb=10, add, resultsrc=10, pcsrc=0.
  - mem_ready=1: irwrite=1, pcwrite=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alusrca=01, alusrcb=01, add. This precomputes the branch or jump target into aluout; immsrc=J for JAL, else B.
  - Next state by op: LW or SW -> MEMADR; R -> EXECR; I -> EXECI; BEQ -> BRANCH; JAL -> JAL; LUI -> LUI.
  - Any other op -> HALT.
- MEMADR: alusrca=10, alusrcb=01, add, immsrc I for LW or S for SW. Next: LW -> MEMRD, SW -> MEMWR.
- MEMRD: adrsrc=1, memread=1. Go to MEMWB when mem_ready=1.
- MEMWB: resultsrc=01, regwrite=1, then FETCH.
- MEMWR: adrsrc=1, memwrite=1. Go to FETCH when mem_ready=1.
- EXECR: alusrca=10, alusrcb=00, aluop R, then ALUWB.
- EXECI: alusrca=10, alusrcb=01, aluop I, immsrc=I, then ALUWB.
- ALUWB: resultsrc=00, regwrite=1, then FETCH.
- BRANCH: alusrca=10, alusrcb=00, sub, pcsrc=1, pcwrite=zero, then FETCH.
- JAL: alusrca=01, alusrcb=10, add, resultsrc=10, regwrite=1, pcsrc=1, pcwrite=1, then FETCH.
- LUI: resultsrc=11, immsrc=U, regwrite=1, then FETCH.
- HALT: all strobes 0, halted=1. Stays in HALT until reset.
- alucontrol encoding by aluop:
  - add -> 0000
  - sub -> 1000
  - R -> {funct7[5], funct3}
  - I -> {0, funct3}

## Timing
- Reset asserted: state=FETCH immediately (asynchronous). pcwrite, irwrite, regwrite, memread and memwrite are forced 0. halted=0.
- First FETCH request appears in the first cycle after reset deasserts.
- Cycles per instruction with mem_ready tied high:
  - 3: JAL, LUI, BRANCH
  - 4: R, I, SW
  - 5: LW
- Each low mem_ready cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Handshake: memread or memwrite stays high, with adrsrc stable, until the cycle mem_ready is sampled 1; that cycle is the completion.
- mem_ready is ignored in all other states.
- Reset mid-access drops the request in the same cycle. No partial writeback is allowed.

## Structure
- Shared definitions package/header mc_defs: state encodings, opcode constants, and the alusrca/alusrcb/immsrc/resultsrc encodings.
- The datapath also includes mc_defs.
- ALU decode: instantiate the existing aludec sub-module, driven by an internal 2-bit aluop (00 add, 01 sub, 10 R, 11 I).
- Next-state logic and output decode live in this block.

## Test plan
- R add, mem_ready=1: states FETCH, DECODE, EXECR, ALUWB; regwrite=1 only in the 4th cycle; alucontrol=0000 in EXECR. Also check sub (funct7=0100000) gives alucontrol=1000.
- LW, mem_ready low for 2 cycles in MEMRD: memread=1 and adrsrc=1 held 3 cycles; total 7 cycles; regwrite with resultsrc=01 in the last cycle.
- BEQ: zero=1 gives pcwrite=1 and pcsrc=1 in BRANCH; zero=0 gives pcwrite=0. Both return to FETCH in cycle 4.
- JAL: immsrc=011 in DECODE; in the 3rd cycle regwrite=1, pcwrite=1, pcsrc=1, resultsrc=10.
- Opcode 7'b1111111: HALT after DECODE; halted=1 and no strobes for 10+ cycles; reset returns the FSM to FETCH.
- reset pulled low during MEMWR with mem_ready=0: memwrite drops the same cycle and state=FETCH. After release, FETCH resumes with memread=1.
